// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - phase-accumulator oversample/mid/bit tick generator; optional baud_clk via BAUD_CLK_OUT_EN
module baud_tick_gen #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD0      = 9600,
  parameter int unsigned BAUD1      = 19200,
  parameter int unsigned BAUD2      = 57600,
  parameter int unsigned BAUD3      = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_W      = 24
) (
  input  logic       clk50MHz,
  input  logic       nReset,
  input  logic       enable,
  input  logic       resync,
  input  logic [1:0] rate_sel,
  output logic       os_tick,
  output logic       mid_tick,
  output logic       bit_tick,
  output logic       baud_clk
);

  localparam int unsigned OS_W    = $clog2(OVERSAMPLE);
  localparam logic [63:0] ACC_ONE = 64'd1 << ACC_W;

  // Rounded phase increment for one rate, evaluated at elaboration only.
  function automatic logic [63:0] calc_inc(input logic [63:0] baud);
    return (baud * 64'(OVERSAMPLE) * ACC_ONE + 64'(CLK_HZ) / 64'd2) / 64'(CLK_HZ);
  endfunction

  localparam logic [63:0] INC0_W = calc_inc(64'(BAUD0));
  localparam logic [63:0] INC1_W = calc_inc(64'(BAUD1));
  localparam logic [63:0] INC2_W = calc_inc(64'(BAUD2));
  localparam logic [63:0] INC3_W = calc_inc(64'(BAUD3));

  localparam logic [ACC_W-1:0] INC0 = INC0_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0] INC1 = INC1_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0] INC2 = INC2_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0] INC3 = INC3_W[ACC_W-1:0];

  localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID_PRE = OS_W'(OVERSAMPLE / 2 - 1);

  // Reject configurations that cannot produce a usable tick stream.
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("baud_tick_gen: OVERSAMPLE must be an even integer >= 4");
  end
  if (ACC_W < 20) begin : g_bad_accw
    $error("baud_tick_gen: ACC_W must be >= 20");
  end
  if (INC0_W == 64'd0 || INC0_W >= ACC_ONE ||
      INC1_W == 64'd0 || INC1_W >= ACC_ONE ||
      INC2_W == 64'd0 || INC2_W >= ACC_ONE ||
      INC3_W == 64'd0 || INC3_W >= ACC_ONE) begin : g_bad_inc
    $error("baud_tick_gen: a baud increment rounds to 0 or overflows the accumulator");
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] inc_sel;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [OS_W-1:0]  os_cnt;
  logic             at_last;
  logic             at_mid;

  // Increment for the currently requested rate; only loaded at bit boundaries or resync.
  always_comb begin
    inc_sel = INC0;
    case (rate_sel)
      2'd0:    inc_sel = INC0;
      2'd1:    inc_sel = INC1;
      2'd2:    inc_sel = INC2;
      default: inc_sel = INC3;
    endcase
  end

  // Next accumulator value; the carry out marks one oversample period.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, inc_q};
    carry   = sum[ACC_W];
    at_last = (os_cnt == OS_LAST);
    at_mid  = (os_cnt == OS_MID_PRE);
  end

  // Phase state and registered tick outputs; resync wins over enable.
  always_ff @(posedge clk50MHz or negedge nReset) begin
    if (!nReset) begin
      acc      <= '0;
      os_cnt   <= '0;
      inc_q    <= INC0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (resync) begin
      acc      <= '0;
      os_cnt   <= '0;
      inc_q    <= inc_sel;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (enable) begin
      acc      <= sum[ACC_W-1:0];
      os_tick  <= carry;
      mid_tick <= carry & at_mid;
      bit_tick <= carry & at_last;
      if (carry) begin
        os_cnt <= at_last ? '0 : os_cnt + OS_W'(1);
      end
      if (carry && at_last) begin
        inc_q <= inc_sel;
      end
    end else begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

`ifdef BAUD_CLK_OUT_EN
  // Bit-rate square wave: rises with each bit tick, falls with each mid tick.
  always_ff @(posedge clk50MHz or negedge nReset) begin
    if (!nReset) begin
      baud_clk <= 1'b0;
    end else if (!resync && enable && carry) begin
      if (at_last) begin
        baud_clk <= 1'b1;
      end else if (at_mid) begin
        baud_clk <= 1'b0;
      end
    end
  end
`else
  assign baud_clk = 1'b0;
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - scoreboard bench for baud_tick_gen tick timing, resync, freeze and reset
module tb_baud_tick_gen;

  localparam int     CLK_HZ  = 50000000;
  localparam int     BAUD0   = 9600;
  localparam int     BAUD1   = 19200;
  localparam int     BAUD2   = 57600;
  localparam int     BAUD3   = 115200;
  localparam int     OS      = 16;
  localparam int     ACC_W   = 24;
  localparam longint ACC_ONE = longint'(1) << ACC_W;

`ifdef BAUD_CLK_OUT_EN
  localparam logic EXP_BC_BIT = 1'b1;
  localparam logic EXP_BC_MID = 1'b0;
  localparam logic EXP_BC_EARLY = 1'b1;
`else
  localparam logic EXP_BC_BIT = 1'b0;
  localparam logic EXP_BC_MID = 1'b0;
  localparam logic EXP_BC_EARLY = 1'b0;
`endif

  logic       clk50MHz = 1'b0;
  logic       nReset   = 1'b0;
  logic       enable   = 1'b0;
  logic       resync   = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic       os_tick;
  logic       mid_tick;
  logic       bit_tick;
  logic       baud_clk;

  baud_tick_gen #(
    .CLK_HZ(CLK_HZ), .BAUD0(BAUD0), .BAUD1(BAUD1), .BAUD2(BAUD2), .BAUD3(BAUD3),
    .OVERSAMPLE(OS), .ACC_W(ACC_W)
  ) dut (
    .clk50MHz(clk50MHz),
    .nReset(nReset),
    .enable(enable),
    .resync(resync),
    .rate_sel(rate_sel),
    .os_tick(os_tick),
    .mid_tick(mid_tick),
    .bit_tick(bit_tick),
    .baud_clk(baud_clk)
  );

  always #5 clk50MHz = ~clk50MHz;

  int cyc = 0;
  always @(posedge clk50MHz) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    lo;
    int    hi;
  } exp_t;

  exp_t   exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     g_last_bit = 0;
  longint inc0;
  longint inc3;

  function automatic longint inc_ref(int baud);
    real r;
    r = real'(baud) * real'(OS) * real'(ACC_ONE) / real'(CLK_HZ);
    return longint'($floor(r + 0.5));
  endfunction

  // Number of accumulating edges until the k-th carry, counted from a zeroed accumulator.
  function automatic int carry_edge(longint inc, int k);
    return int'((longint'(k) * ACC_ONE + inc - 1) / inc);
  endfunction

  function automatic int ideal_bit(int baud);
    return int'($floor(real'(CLK_HZ) / real'(baud) + 0.5));
  endfunction

  task automatic wait_for(input int which, input int budget, output int t, output bit ok);
    ok = 1'b0;
    t  = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk50MHz);
      if ((which == 0 && os_tick) || (which == 1 && mid_tick) || (which == 2 && bit_tick)) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int   t0;
    int   t;
    bit   ok;
    nReset = 1'b0; enable = 1'b1; resync = 1'b0; rate_sel = 2'd3;
    repeat (3) @(negedge clk50MHz);
    n_tests++;
    if ({os_tick, mid_tick, bit_tick, baud_clk} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=0000", {os_tick, mid_tick, bit_tick, baud_clk});
    end
    // reset loads INC0 regardless of rate_sel, so the first bit runs at BAUD0? no: rate 3 is loaded only at bit end
    nReset = 1'b0;
    @(negedge clk50MHz);
    nReset = 1'b1;
    rate_sel = 2'd3;
    t0 = cyc;
    exp_q.push_back('{name:"reset_first_os",  lo:carry_edge(inc0, 1),  hi:carry_edge(inc0, 1)});
    exp_q.push_back('{name:"reset_first_mid", lo:carry_edge(inc0, OS/2), hi:carry_edge(inc0, OS/2)});
    exp_q.push_back('{name:"reset_first_bit", lo:carry_edge(inc0, OS), hi:carry_edge(inc0, OS)});
    wait_for(0, 1000, t, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || t - t0 < e.lo || t - t0 > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, t - t0, e.lo, e.hi);
    end
    wait_for(1, 5000, t, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || t - t0 < e.lo || t - t0 > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, t - t0, e.lo, e.hi);
    end
    wait_for(2, 5000, t, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || t - t0 < e.lo || t - t0 > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, t - t0, e.lo, e.hi);
    end
    g_last_bit = t;
  endtask

  task automatic test_fast_rate();
    exp_t e;
    int   t_os;
    int   t_bit;
    int   n_os;
    int   bits;
    int   os_lo;
    os_lo = int'(ACC_ONE / inc3);
    t_os  = g_last_bit;
    t_bit = g_last_bit;
    n_os  = 0;
    bits  = 0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < OS; i++) exp_q.push_back('{name:"fast_os_interval", lo:os_lo, hi:os_lo + 1});
      exp_q.push_back('{name:"fast_bit_spacing", lo:ideal_bit(BAUD3) - 1, hi:ideal_bit(BAUD3) + 1});
    end
    for (int c = 0; c < 2000 && bits < 2; c++) begin
      @(negedge clk50MHz);
      if (os_tick) begin
        n_os++;
        e = exp_q.pop_front();
        n_tests++;
        if (cyc - t_os < e.lo || cyc - t_os > e.hi) begin
          n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, cyc - t_os, e.lo, e.hi);
        end
        t_os = cyc;
      end
      if (mid_tick) begin
        n_tests++;
        if (n_os != OS / 2 || baud_clk !== EXP_BC_MID) begin
          n_fail++; $display("FAIL fast_mid_pos got os=%0d bclk=%b exp os=%0d bclk=%b", n_os, baud_clk, OS / 2, EXP_BC_MID);
        end
      end
      if (bit_tick) begin
        e = exp_q.pop_front();
        n_tests++;
        if (cyc - t_bit < e.lo || cyc - t_bit > e.hi) begin
          n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, cyc - t_bit, e.lo, e.hi);
        end
        n_tests++;
        if (n_os != OS || baud_clk !== EXP_BC_BIT) begin
          n_fail++; $display("FAIL fast_os_per_bit got os=%0d bclk=%b exp os=%0d bclk=%b", n_os, baud_clk, OS, EXP_BC_BIT);
        end
        t_bit = cyc; n_os = 0; bits++;
      end
    end
    n_tests++;
    if (bits != 2) begin
      n_fail++; $display("FAIL fast_timeout got bits=%0d exp=2", bits);
    end
    g_last_bit = t_bit;
  endtask

  task automatic test_slow_rate();
    exp_t e;
    int   t_r;
    int   t_os;
    int   t_bit;
    int   t_first;
    int   bits;
    int   os_min;
    int   os_max;
    int   os_lo;
    int   tot;
    os_lo = int'(ACC_ONE / inc0);
    @(negedge clk50MHz);
    rate_sel = 2'd0; resync = 1'b1;
    @(negedge clk50MHz);
    resync = 1'b0;
    t_r = cyc;
    exp_q.push_back('{name:"slow_first_bit", lo:carry_edge(inc0, OS), hi:carry_edge(inc0, OS)});
    for (int b = 0; b < 3; b++)
      exp_q.push_back('{name:"slow_bit_spacing", lo:ideal_bit(BAUD0) - 1, hi:ideal_bit(BAUD0) + 1});
    tot = int'($floor(3.0 * real'(OS) * real'(ACC_ONE) / real'(inc0) + 0.5));
    exp_q.push_back('{name:"slow_total_3bits", lo:tot - 2, hi:tot + 2});
    n_tests++;
    if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
      n_fail++; $display("FAIL slow_resync_quiet0 got=%b exp=000", {os_tick, mid_tick, bit_tick});
    end
    @(negedge clk50MHz);
    n_tests++;
    if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
      n_fail++; $display("FAIL slow_resync_quiet1 got=%b exp=000", {os_tick, mid_tick, bit_tick});
    end
    t_os = -1; t_bit = t_r; t_first = t_r; bits = 0; os_min = 1 << 30; os_max = 0;
    for (int c = 0; c < 25000 && bits < 4; c++) begin
      @(negedge clk50MHz);
      if (os_tick) begin
        if (t_os >= 0) begin
          if (cyc - t_os < os_min) os_min = cyc - t_os;
          if (cyc - t_os > os_max) os_max = cyc - t_os;
        end
        t_os = cyc;
      end
      if (bit_tick) begin
        e = exp_q.pop_front();
        n_tests++;
        if (cyc - t_bit < e.lo || cyc - t_bit > e.hi) begin
          n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, cyc - t_bit, e.lo, e.hi);
        end
        if (bits == 0) t_first = cyc;
        t_bit = cyc; bits++;
      end
    end
    e = exp_q.pop_front();
    n_tests++;
    if (bits != 4 || t_bit - t_first < e.lo || t_bit - t_first > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d bits=%0d exp=%0d..%0d", e.name, t_bit - t_first, bits, e.lo, e.hi);
    end
    n_tests++;
    if (os_min < os_lo || os_max > os_lo + 1) begin
      n_fail++; $display("FAIL slow_os_interval got=%0d..%0d exp=%0d..%0d", os_min, os_max, os_lo, os_lo + 1);
    end
    g_last_bit = t_bit;
  endtask

  task automatic test_rate_change();
    exp_t e;
    int   t;
    bit   ok;
    repeat (1000) @(negedge clk50MHz);
    rate_sel = 2'd3;
    exp_q.push_back('{name:"chg_current_bit", lo:ideal_bit(BAUD0) - 1, hi:ideal_bit(BAUD0) + 1});
    exp_q.push_back('{name:"chg_next_bit", lo:ideal_bit(BAUD3) - 1, hi:ideal_bit(BAUD3) + 1});
    wait_for(2, 6000, t, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || t - g_last_bit < e.lo || t - g_last_bit > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, t - g_last_bit, e.lo, e.hi);
    end
    g_last_bit = t;
    wait_for(2, 1000, t, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || t - g_last_bit < e.lo || t - g_last_bit > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, t - g_last_bit, e.lo, e.hi);
    end
    g_last_bit = t;
  endtask

  task automatic test_resync();
    exp_t e;
    int   t_r;
    int   t;
    bit   ok;
    repeat (100) @(negedge clk50MHz);
    resync = 1'b1;
    @(negedge clk50MHz);
    resync = 1'b0;
    t_r = cyc;
    exp_q.push_back('{name:"resync_mid", lo:carry_edge(inc3, OS/2), hi:carry_edge(inc3, OS/2)});
    exp_q.push_back('{name:"resync_bit", lo:carry_edge(inc3, OS), hi:carry_edge(inc3, OS)});
    n_tests++;
    if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
      n_fail++; $display("FAIL resync_quiet0 got=%b exp=000", {os_tick, mid_tick, bit_tick});
    end
    @(negedge clk50MHz);
    n_tests++;
    if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
      n_fail++; $display("FAIL resync_quiet1 got=%b exp=000", {os_tick, mid_tick, bit_tick});
    end
    wait_for(1, 1000, t, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || t - t_r < e.lo || t - t_r > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, t - t_r, e.lo, e.hi);
    end
    wait_for(2, 1000, t, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || t - t_r < e.lo || t - t_r > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, t - t_r, e.lo, e.hi);
    end
    g_last_bit = t;
  endtask

  task automatic test_freeze();
    exp_t e;
    int   ticks;
    int   t;
    bit   ok;
    repeat (150) @(negedge clk50MHz);
    enable = 1'b0;
    exp_q.push_back('{name:"freeze_ticks", lo:0, hi:0});
    exp_q.push_back('{name:"freeze_bit_active_time", lo:ideal_bit(BAUD3) - 1, hi:ideal_bit(BAUD3) + 1});
    ticks = 0;
    repeat (1000) begin
      @(negedge clk50MHz);
      if (os_tick || mid_tick || bit_tick) ticks++;
    end
    enable = 1'b1;
    e = exp_q.pop_front();
    n_tests++;
    if (ticks < e.lo || ticks > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, ticks, e.lo, e.hi);
    end
    wait_for(2, 1000, t, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || t - g_last_bit - 1000 < e.lo || t - g_last_bit - 1000 > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, t - g_last_bit - 1000, e.lo, e.hi);
    end
    g_last_bit = t;
  endtask

  task automatic test_reset_midbit();
    exp_t e;
    int   t0;
    int   t;
    bit   ok;
    repeat (150) @(negedge clk50MHz);
    n_tests++;
    if (baud_clk !== EXP_BC_EARLY) begin
      n_fail++; $display("FAIL midbit_baud_clk got=%b exp=%b", baud_clk, EXP_BC_EARLY);
    end
    #2 nReset = 1'b0;
    #1;
    n_tests++;
    if ({os_tick, mid_tick, bit_tick, baud_clk} !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset_outputs got=%b exp=0000", {os_tick, mid_tick, bit_tick, baud_clk});
    end
    @(negedge clk50MHz);
    nReset = 1'b1;
    t0 = cyc;
    exp_q.push_back('{name:"rst_midbit_first_os", lo:carry_edge(inc0, 1), hi:carry_edge(inc0, 1)});
    exp_q.push_back('{name:"resync_disabled_first_os", lo:carry_edge(inc3, 1), hi:carry_edge(inc3, 1)});
    wait_for(0, 1000, t, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || t - t0 < e.lo || t - t0 > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, t - t0, e.lo, e.hi);
    end
    enable = 1'b0; rate_sel = 2'd3; resync = 1'b1;
    @(negedge clk50MHz);
    resync = 1'b0;
    repeat (5) @(negedge clk50MHz);
    enable = 1'b1;
    t0 = cyc;
    wait_for(0, 1000, t, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || t - t0 < e.lo || t - t0 > e.hi) begin
      n_fail++; $display("FAIL %s got=%0d exp=%0d..%0d", e.name, t - t0, e.lo, e.hi);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    inc0 = inc_ref(BAUD0);
    inc3 = inc_ref(BAUD3);
    test_reset();
    test_fast_rate();
    test_slow_rate();
    test_rate_change();
    test_resync();
    test_freeze();
    test_reset_midbit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
